acc_exec: RTL and testbench
===========================

ACC_EXEC -- requirements
Module: acc_exec

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  instruction offered; in_ready  out  1  instruction accepted when both high at an edge.
REQ-004 SHALL have ports: in_op  in  4  ALU opcode; in_xy  in  1  shift direction (1 = right); in_b  in  8  operand B; in_wr  in  1  write result to accumulator; in_cnt  in  3  extra passes (macro only).
REQ-005 SHALL have ports: alu_a  out  8, alu_b  out  8, alu_op  out  4, alu_xy  out  1, alu_cin  out  1: drive the external combinational ALU.
REQ-006 SHALL have ports: alu_q  in  8, alu_cout  in  1: ALU result and carry.
REQ-007 SHALL have ports: acc  out  8  accumulator; carry  out  1  carry flag; done  out  1  one-cycle completion pulse.

Function
REQ-008 SHALL implement states IDLE and EXEC; in_ready = 1 only in IDLE.
REQ-009 SHALL, on accept, latch in_op, in_xy, in_b, in_wr into registers and go to EXEC next cycle.
REQ-010 SHALL drive alu_a = acc, alu_b/alu_op/alu_xy from the latched registers, alu_cin = carry, combinationally from registers at all times.
REQ-011 SHALL, at the edge ending an EXEC pass: carry <= alu_cout always; acc <= alu_q only if latched wr = 1.
REQ-012 SHALL, on the final pass, return to IDLE and assert done for exactly the following cycle.
REQ-013 SHALL give single-pass latency: accept edge T0, acc/carry updated at edge T1, done high T1..T2; throughput one instruction per 2 cycles.
REQ-014 SHALL accept a new instruction in the same cycle done is high (in_ready already high).
REQ-015 SHALL ignore in_valid and all in_* while in EXEC; latched registers do not change.
REQ-016 SHALL hold acc and carry unchanged in IDLE.
REQ-017 SHALL keep alu_* outputs holding last latched values while idle.

Reset
REQ-018 SHALL on rst: state IDLE, acc = 0x00, carry = 0, done = 0, latched op/xy/b/wr = 0, repeat counter = 0.
REQ-019 SHALL on rst during EXEC abort without writeback; rst takes priority over accept and writeback in the same cycle.
REQ-020 SHALL have in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-021 SHALL, with ACC_EXEC_REPEAT_EN defined, latch in_cnt on accept; for in_op[3:2] = 2'b11 perform in_cnt+1 consecutive EXEC passes, each applying REQ-011 with the updated acc/carry; done only after the last pass; other opcodes use one pass.
REQ-022 SHALL, without ACC_EXEC_REPEAT_EN, ignore in_cnt, contain no counter, and always execute one pass.
REQ-023 SHALL, with the macro, keep in_ready low for all passes and count with a 3-bit down-counter (max 8 passes).

Verification
REQ-024 Load: rst; op 0x0, b 0xF0, wr 1 -> acc 0xF0, carry 0 (old acc[7]), done one cycle, 2 cycles accept-to-accept.
REQ-025 Add/adc chain: after REQ-024, op 0x8 b 0x20 wr 1 -> acc 0x10 carry 1; then op 0x9 b 0x00 -> acc 0x11 carry 0.
REQ-026 Flag-only: acc 0x11, op 0x2 b 0x00 wr 0 -> acc stays 0x11, carry 1 (a != 0).
REQ-027 Repeat (macro on): acc 0x81, op 0xC xy 0 cnt 2 wr 1 -> passes 0x02/c1, 0x04/c0, 0x08/c0; done 3 cycles after EXEC start; in_ready low throughout. Macro off: acc 0x02, carry 1 after one pass.
REQ-028 Busy/reset: hold in_valid high during EXEC with different in_b -> no second accept until IDLE; assert rst mid-repeat -> acc 0x00, carry 0, no done, in_ready 1 next cycle.

Source files
------------

// File: rtl/acc_exec.sv
// Accumulator sequencer: accepts one instruction, drives an external combinational ALU
// and writes back. Define ACC_EXEC_REPEAT_EN to enable multi-pass shift instructions.
module acc_exec (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic       in_xy,
   input  logic [7:0] in_b,
   input  logic       in_wr,
   input  logic [2:0] in_cnt,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic       alu_xy,
   output logic       alu_cin,
   input  logic [7:0] alu_q,
   input  logic       alu_cout,
   output logic [7:0] acc,
   output logic       carry,
   output logic       done
);

   typedef enum logic {StIdle, StExec} state_e;

   state_e     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic       xy_q, xy_d;
   logic [7:0] b_q, b_d;
   logic       wr_q, wr_d;
   logic [7:0] acc_q, acc_d;
   logic       carry_q, carry_d;
   logic       done_q, done_d;
   logic       last_pass;

`ifdef ACC_EXEC_REPEAT_EN
   logic [2:0] cnt_q, cnt_d;
   assign last_pass = (cnt_q == 3'd0);
`else
   logic unused_in_cnt;
   assign unused_in_cnt = ^in_cnt;
   assign last_pass     = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      xy_d     = xy_q;
      b_d      = b_q;
      wr_d     = wr_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      done_d   = 1'b0;
      in_ready = (state_q == StIdle);
`ifdef ACC_EXEC_REPEAT_EN
      cnt_d    = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               op_d    = in_op;
               xy_d    = in_xy;
               b_d     = in_b;
               wr_d    = in_wr;
               state_d = StExec;
`ifdef ACC_EXEC_REPEAT_EN
               // Only shift-class opcodes repeat; everything else is a single pass.
               cnt_d   = (in_op[3:2] == 2'b11) ? in_cnt : 3'd0;
`endif
            end
         end
         StExec: begin
            carry_d = alu_cout;
            if (wr_q) acc_d = alu_q;
            if (last_pass) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
`ifdef ACC_EXEC_REPEAT_EN
            else begin
               cnt_d = cnt_q - 3'd1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         op_q    <= 4'h0;
         xy_q    <= 1'b0;
         b_q     <= 8'h00;
         wr_q    <= 1'b0;
         acc_q   <= 8'h00;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef ACC_EXEC_REPEAT_EN
         cnt_q   <= 3'd0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         xy_q    <= xy_d;
         b_q     <= b_d;
         wr_q    <= wr_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         done_q  <= done_d;
`ifdef ACC_EXEC_REPEAT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign alu_a   = acc_q;
   assign alu_b   = b_q;
   assign alu_op  = op_q;
   assign alu_xy  = xy_q;
   assign alu_cin = carry_q;
   assign acc     = acc_q;
   assign carry   = carry_q;
   assign done    = done_q;

endmodule

// File: tb/tb_acc_exec.sv
// Directed bench for acc_exec with a small behavioural ALU attached to the alu_* ports.
// Works with or without ACC_EXEC_REPEAT_EN defined.
module tb_acc_exec;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic       in_xy;
   logic [7:0] in_b;
   logic       in_wr;
   logic [2:0] in_cnt;
   logic [7:0] alu_a, alu_b, alu_q;
   logic [3:0] alu_op;
   logic       alu_xy, alu_cin, alu_cout;
   logic [7:0] acc;
   logic       carry, done;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   acc_exec dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_xy    (in_xy),
      .in_b     (in_b),
      .in_wr    (in_wr),
      .in_cnt   (in_cnt),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_xy   (alu_xy),
      .alu_cin  (alu_cin),
      .alu_q    (alu_q),
      .alu_cout (alu_cout),
      .acc      (acc),
      .carry    (carry),
      .done     (done)
   );

   // Reference ALU: 0 load, 2 test-nonzero, 8 add, 9 adc, C shift (xy=1 right).
   logic [8:0] sum;
   always_comb begin
      sum      = 9'd0;
      alu_q    = alu_a;
      alu_cout = 1'b0;
      case (alu_op)
         4'h0: begin alu_q = alu_b; alu_cout = alu_a[7]; end
         4'h2: begin alu_q = alu_a; alu_cout = |alu_a; end
         4'h8: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; {alu_cout, alu_q} = sum; end
         4'h9: begin
            sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            {alu_cout, alu_q} = sum;
         end
         4'hC: begin
            if (alu_xy) begin alu_q = {1'b0, alu_a[7:1]}; alu_cout = alu_a[0]; end
            else        begin alu_q = {alu_a[6:0], 1'b0}; alu_cout = alu_a[7]; end
         end
         default: ;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic xy, input logic [7:0] b,
                        input logic wr, input logic [2:0] cnt);
      in_op    = op;
      in_xy    = xy;
      in_b     = b;
      in_wr    = wr;
      in_cnt   = cnt;
      in_valid = 1'b1;
   endtask

   // Issue one instruction, wait (bounded) for done, and check the writeback.
   task automatic run(input logic [3:0] op, input logic xy, input logic [7:0] b,
                      input logic wr, input logic [2:0] cnt, input logic [7:0] e_acc,
                      input logic e_c, input int e_passes);
      int n;
      drive(op, xy, b, wr, cnt);
      chk("accept_ready", {7'd0, in_ready}, 8'd1);
      step();
      in_valid = 1'b0;
      chk("exec_busy", {7'd0, in_ready}, 8'd0);
      n = 0;
      do begin
         step();
         n++;
      end while (!done && n < 20);
      chk("passes", n[7:0], e_passes[7:0]);
      chk("acc", acc, e_acc);
      chk("carry", {7'd0, carry}, {7'd0, e_c});
      chk("done_ready", {7'd0, in_ready}, 8'd1);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_op    = 4'h0;
      in_xy    = 1'b0;
      in_b     = 8'h00;
      in_wr    = 1'b0;
      in_cnt   = 3'd0;
      step();
      step();
      chk("rst_acc", acc, 8'h00);
      chk("rst_carry", {7'd0, carry}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_alu_b", alu_b, 8'h00);
      rst = 1'b0;
      chk("rst_ready", {7'd0, in_ready}, 8'd1);

      // Load, then add/adc chain issued back-to-back in the done cycle.
      run(4'h0, 1'b0, 8'hF0, 1'b1, 3'd0, 8'hF0, 1'b0, 1);
      run(4'h8, 1'b0, 8'h20, 1'b1, 3'd0, 8'h10, 1'b1, 1);
      run(4'h9, 1'b0, 8'h00, 1'b1, 3'd0, 8'h11, 1'b0, 1);
      // Flag-only: no writeback.
      run(4'h2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h11, 1'b1, 1);
      step();
      chk("done_pulse", {7'd0, done}, 8'd0);
      chk("idle_alu_op", {4'd0, alu_op}, 8'h02);
      chk("idle_alu_a", alu_a, 8'h11);
      chk("idle_alu_cin", {7'd0, alu_cin}, 8'd1);
      step();
      chk("idle_hold_acc", acc, 8'h11);

      run(4'h0, 1'b0, 8'h81, 1'b1, 3'd0, 8'h81, 1'b0, 1);
`ifdef ACC_EXEC_REPEAT_EN
      drive(4'hC, 1'b0, 8'h00, 1'b1, 3'd2);
      step();
      in_valid = 1'b0;
      step();
      chk("rep1_acc", acc, 8'h02);
      chk("rep1_c", {7'd0, carry}, 8'd1);
      chk("rep1_ready", {7'd0, in_ready}, 8'd0);
      chk("rep1_done", {7'd0, done}, 8'd0);
      step();
      chk("rep2_acc", acc, 8'h04);
      chk("rep2_c", {7'd0, carry}, 8'd0);
      chk("rep2_ready", {7'd0, in_ready}, 8'd0);
      step();
      chk("rep3_acc", acc, 8'h08);
      chk("rep3_c", {7'd0, carry}, 8'd0);
      chk("rep3_done", {7'd0, done}, 8'd1);
      step();
      // Non-shift opcode ignores cnt.
      run(4'h0, 1'b0, 8'h05, 1'b1, 3'd5, 8'h05, 1'b0, 1);
`else
      run(4'hC, 1'b0, 8'h00, 1'b1, 3'd2, 8'h02, 1'b1, 1);
      run(4'h0, 1'b0, 8'h05, 1'b1, 3'd5, 8'h05, 1'b0, 1);
`endif
      run(4'hC, 1'b1, 8'h00, 1'b1, 3'd0, 8'h02, 1'b1, 1);
      chk("alu_xy", {7'd0, alu_xy}, 8'd1);

      // Busy: valid held high with a changed operand is ignored until idle.
      drive(4'h0, 1'b0, 8'h33, 1'b1, 3'd0);
      step();
      in_b = 8'h77;
      chk("busy_ready", {7'd0, in_ready}, 8'd0);
      chk("busy_alu_b", alu_b, 8'h33);
      step();
      chk("busy_acc", acc, 8'h33);
      chk("busy_done", {7'd0, done}, 8'd1);
      step();
      in_valid = 1'b0;
      chk("second_alu_b", alu_b, 8'h77);
      step();
      chk("second_acc", acc, 8'h77);

      // Reset during execution aborts with no writeback and no done.
      step();
      drive(4'hC, 1'b0, 8'h00, 1'b1, 3'd3);
      step();
      in_valid = 1'b0;
`ifdef ACC_EXEC_REPEAT_EN
      step();
      chk("pre_rst_acc", acc, 8'hEE);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_acc", acc, 8'h00);
      chk("abort_carry", {7'd0, carry}, 8'd0);
      chk("abort_done", {7'd0, done}, 8'd0);
      chk("abort_ready", {7'd0, in_ready}, 8'd1);
      chk("abort_alu_op", {4'd0, alu_op}, 8'h00);
      step();
      chk("abort_no_done", {7'd0, done}, 8'd0);
      chk("abort_hold", acc, 8'h00);

      run(4'h8, 1'b0, 8'h05, 1'b1, 3'd0, 8'h05, 1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
